// File: rtl/bullets_manager.sv
// Player-bullet sprite stage: allocates slots on fire, moves bullets once per frame,
// retires them off-screen or on hit, and emits registered per-slot draw requests.
module bullets_manager #(
  parameter int         NUM_BULLETS   = 3,
  parameter int         BULLET_W      = 4,
  parameter int         BULLET_H      = 8,
  parameter int         SPEED         = 4,
  parameter int         FIRE_COOLDOWN = 8,
  parameter logic [7:0] BULLET_COLOR  = 8'hFC
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   startOfFrame,
  input  logic [10:0]            pixelX,
  input  logic [10:0]            pixelY,
  input  logic                   fireReq,
  input  logic [10:0]            shooterX,
  input  logic [10:0]            shooterY,
  input  logic [NUM_BULLETS-1:0] hitBullet,
  output logic                   fireAck,
  output logic [NUM_BULLETS-1:0] bulletDrawingRequest,
  output logic [7:0]             bulletRGB,
  output logic [1:0]             activeCount
);

  localparam int CD_W  = (FIRE_COOLDOWN < 2) ? 1 : $clog2(FIRE_COOLDOWN + 1);
  localparam int CNT_W = $clog2(NUM_BULLETS + 1) + 2;

  // Per-slot FSM state: a set bit means FLYING, clear means IDLE.
  logic [NUM_BULLETS-1:0] flying, flying_next;
  logic [10:0]            x [NUM_BULLETS];
  logic [10:0]            y [NUM_BULLETS];
  logic [10:0]            x_next [NUM_BULLETS];
  logic [10:0]            y_next [NUM_BULLETS];
  logic [CD_W-1:0]        cooldown;
  logic [NUM_BULLETS-1:0] alloc, draw_hit;
  logic                   found, accept;
  logic [CNT_W-1:0]       cnt;

  // Free-slot search looks only at registered state, so a slot hit this cycle is not yet free.
  always_comb begin
    alloc = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (!flying[i] && !found) begin
        alloc[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign accept = fireReq && (cooldown == '0) && found && (shooterY >= 11'(BULLET_H));

  // Hit beats move; a slot allocated this cycle was IDLE, so it cannot also move.
  always_comb begin
    flying_next = flying;
    cnt         = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      x_next[i] = x[i];
      y_next[i] = y[i];
      if (flying[i]) begin
        if (hitBullet[i]) begin
          flying_next[i] = 1'b0;
        end else if (startOfFrame) begin
          if (y[i] < 11'(SPEED)) flying_next[i] = 1'b0;
          else                   y_next[i]      = y[i] - 11'(SPEED);
        end
      end else if (accept && alloc[i]) begin
        flying_next[i] = 1'b1;
        x_next[i]      = shooterX;
        y_next[i]      = shooterY - 11'(BULLET_H);
      end
      cnt = cnt + CNT_W'(flying_next[i]);
    end
  end

  // Box test in 12 bits so x+W / y+H cannot wrap at the right/bottom screen edge.
  always_comb begin
    for (int i = 0; i < NUM_BULLETS; i++) begin
      draw_hit[i] = flying[i]
                 && ({1'b0, pixelX} >= {1'b0, x[i]})
                 && ({1'b0, pixelX} <  ({1'b0, x[i]} + 12'(BULLET_W)))
                 && ({1'b0, pixelY} >= {1'b0, y[i]})
                 && ({1'b0, pixelY} <  ({1'b0, y[i]} + 12'(BULLET_H)));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flying               <= '0;
      cooldown             <= '0;
      fireAck              <= 1'b0;
      bulletDrawingRequest <= '0;
      bulletRGB            <= 8'h00;
      activeCount          <= 2'd0;
    end else begin
      flying  <= flying_next;
      fireAck <= accept;
      if (accept)                            cooldown <= CD_W'(FIRE_COOLDOWN);
      else if (startOfFrame && cooldown != '0) cooldown <= cooldown - 1'b1;
      bulletDrawingRequest <= draw_hit;
      bulletRGB            <= (|draw_hit) ? BULLET_COLOR : 8'h00;
      activeCount          <= (cnt > CNT_W'(3)) ? 2'd3 : cnt[1:0];
    end
  end

  // Coordinates are only meaningful while the slot is FLYING, so they carry no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BULLETS; i++) begin
      x[i] <= x_next[i];
      y[i] <= y_next[i];
    end
  end

endmodule

// File: tb/tb_bullets_manager.sv
// Directed bench for bullets_manager: a vector table for the main flow plus
// hand-written sequences for slot exhaustion, simultaneous events, reset and retirement.
module tb_bullets_manager;

  logic        clk = 1'b0;
  logic        reset;
  logic        startOfFrame;
  logic [10:0] pixelX, pixelY, shooterX, shooterY;
  logic        fireReq;
  logic [2:0]  hitBullet;
  logic        fireAck;
  logic [2:0]  bulletDrawingRequest;
  logic [7:0]  bulletRGB;
  logic [1:0]  activeCount;

  int compared = 0;
  int mismatched = 0;

  bullets_manager dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
    .pixelX(pixelX), .pixelY(pixelY), .fireReq(fireReq),
    .shooterX(shooterX), .shooterY(shooterY), .hitBullet(hitBullet),
    .fireAck(fireAck), .bulletDrawingRequest(bulletDrawingRequest),
    .bulletRGB(bulletRGB), .activeCount(activeCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sof;
    int         px, py;
    logic       fire;
    int         sx, sy;
    logic [2:0] hit;
    logic       exp_ack;
    logic [2:0] exp_req;
    logic [7:0] exp_rgb;
    logic [1:0] exp_cnt;
  } vec_t;

  vec_t tbl[$];
  int   tag = 0;

  function automatic vec_t mk(logic sof, int px, int py, logic fire, int sx, int sy,
                              logic [2:0] hit, logic ack, logic [2:0] req, logic [1:0] cnt);
    vec_t v;
    v.sof = sof; v.px = px; v.py = py; v.fire = fire; v.sx = sx; v.sy = sy; v.hit = hit;
    v.exp_ack = ack; v.exp_req = req; v.exp_cnt = cnt;
    v.exp_rgb = (req != 3'b000) ? 8'hFC : 8'h00;
    return v;
  endfunction

  function automatic vec_t idle(int px, int py, logic [2:0] req, logic [1:0] cnt);
    return mk(1'b0, px, py, 1'b0, 0, 0, 3'b000, 1'b0, req, cnt);
  endfunction

  function automatic vec_t sofv(logic [1:0] cnt);
    return mk(1'b1, 0, 0, 1'b0, 0, 0, 3'b000, 1'b0, 3'b000, cnt);
  endfunction

  task automatic check(input string nm, input int t, input logic [7:0] act, input logic [7:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s step %0d: got %0h, expected %0h", nm, t, act, req);
    end
  endtask

  task automatic run(input vec_t v);
    startOfFrame = v.sof;
    pixelX = 11'(v.px); pixelY = 11'(v.py);
    fireReq = v.fire;
    shooterX = 11'(v.sx); shooterY = 11'(v.sy);
    hitBullet = v.hit;
    @(posedge clk); #1;
    check("fireAck", tag, {7'd0, fireAck}, {7'd0, v.exp_ack});
    check("drawReq", tag, {5'd0, bulletDrawingRequest}, {5'd0, v.exp_req});
    check("rgb", tag, bulletRGB, v.exp_rgb);
    check("activeCount", tag, {6'd0, activeCount}, {6'd0, v.exp_cnt});
    tag++;
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_ack"}, tag, {7'd0, fireAck}, 8'h00);
    check({nm, "_req"}, tag, {5'd0, bulletDrawingRequest}, 8'h00);
    check({nm, "_rgb"}, tag, bulletRGB, 8'h00);
    check({nm, "_cnt"}, tag, {6'd0, activeCount}, 8'h00);
  endtask

  initial begin
    reset = 1'b1; startOfFrame = 1'b0; pixelX = '0; pixelY = '0;
    fireReq = 1'b0; shooterX = '0; shooterY = '0; hitBullet = '0;

    // Single fire, drawing window edges, cooldown, low-shooter rejection, retire, hits.
    tbl.push_back(mk(0, 0, 0, 1, 100, 200, 3'b000, 1, 3'b000, 1));
    tbl.push_back(idle(101, 192, 3'b001, 1));
    tbl.push_back(idle(104, 192, 3'b000, 1));
    tbl.push_back(idle(100, 199, 3'b001, 1));
    tbl.push_back(idle(100, 200, 3'b000, 1));
    tbl.push_back(sofv(1));
    tbl.push_back(idle(101, 188, 3'b001, 1));
    tbl.push_back(idle(104, 188, 3'b000, 1));
    tbl.push_back(mk(0, 0, 0, 1, 50, 100, 3'b000, 0, 3'b000, 1));
    for (int i = 0; i < 7; i++) tbl.push_back(sofv(1));
    tbl.push_back(mk(0, 0, 0, 1, 50, 100, 3'b000, 1, 3'b000, 2));
    tbl.push_back(idle(53, 99, 3'b010, 2));
    tbl.push_back(idle(100, 160, 3'b001, 2));
    for (int i = 0; i < 8; i++) tbl.push_back(sofv(2));
    tbl.push_back(mk(0, 0, 0, 1, 10, 7, 3'b000, 0, 3'b000, 2));
    tbl.push_back(mk(0, 0, 0, 1, 10, 8, 3'b000, 1, 3'b000, 3));
    tbl.push_back(idle(10, 0, 3'b100, 3));
    tbl.push_back(sofv(2));
    tbl.push_back(idle(10, 0, 3'b000, 2));
    tbl.push_back(mk(0, 100, 124, 0, 0, 0, 3'b100, 0, 3'b001, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3'b001, 0, 3'b000, 1));
    tbl.push_back(idle(100, 124, 3'b000, 1));
    tbl.push_back(idle(53, 63, 3'b010, 1));

    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) run(tbl[i]);

    // Fill all three slots, then a fourth request is refused.
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    run(mk(0, 0, 0, 1, 200, 600, 3'b000, 1, 3'b000, 1));
    repeat (8) run(sofv(1));
    run(mk(0, 0, 0, 1, 300, 600, 3'b000, 1, 3'b000, 2));
    repeat (8) run(sofv(2));
    run(mk(0, 0, 0, 1, 400, 600, 3'b000, 1, 3'b000, 3));
    repeat (8) run(sofv(3));
    run(mk(0, 0, 0, 1, 500, 600, 3'b000, 0, 3'b000, 3));

    // Hit + frame + fire together with all slots full: slot1 freed, no ack until next cycle.
    run(mk(1, 0, 0, 1, 600, 600, 3'b010, 0, 3'b000, 2));
    run(mk(0, 0, 0, 1, 600, 600, 3'b000, 1, 3'b000, 3));
    run(idle(603, 599, 3'b010, 3));
    run(idle(400, 556, 3'b100, 3));
    run(idle(200, 492, 3'b001, 3));

    // Reset mid-flight with two bullets clears outputs without a clock edge.
    run(mk(0, 0, 0, 0, 0, 0, 3'b001, 0, 3'b000, 2));
    run(idle(600, 592, 3'b010, 2));
    reset = 1'b1;
    #2;
    check_zero("async_reset");
    @(posedge clk); #1 reset = 1'b0;
    run(idle(600, 592, 3'b000, 0));
    run(idle(400, 556, 3'b000, 0));

    // Right-edge bullet and retirement from y=6 with SPEED=4.
    run(mk(0, 0, 0, 1, 2045, 14, 3'b000, 1, 3'b000, 1));
    run(idle(2047, 6, 3'b001, 1));
    run(idle(2044, 6, 3'b000, 1));
    run(mk(1, 2047, 13, 0, 0, 0, 3'b000, 0, 3'b001, 1));
    run(idle(2046, 2, 3'b001, 1));
    run(idle(2046, 1, 3'b000, 1));
    run(sofv(0));
    run(idle(2046, 2, 3'b000, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
